// File: rtl/out_port_buffers_pkg.sv
// Shared constants for the per-router output-port FIFO bank.
// Port index order everywhere: R, L, U, D, EJ from the high bit down.
package out_port_buffers_pkg;

    localparam int NUM_PORTS = 5;
    localparam int CNT_W     = 3;

    localparam int PORT_R  = 4;
    localparam int PORT_L  = 3;
    localparam int PORT_U  = 2;
    localparam int PORT_D  = 1;
    localparam int PORT_EJ = 0;

endpackage

// File: rtl/out_port_buffers_if.sv
// Crossbar-side write bus, link-side read bus and status outputs of the FIFO bank.
// The master modport is the crossbar/link side; the slave modport is the buffer bank.
interface out_port_buffers_if #(
    parameter int FLIT_W = 32
);
    import out_port_buffers_pkg::*;

    logic [NUM_PORTS-1:0]        wr_en;
    logic [NUM_PORTS*FLIT_W-1:0] wr_flit;
    logic [NUM_PORTS-1:0]        rd_en;
    logic [NUM_PORTS*FLIT_W-1:0] rd_flit;
    logic [CNT_W-1:0]            e_empl;
    logic [CNT_W-1:0]            w_empl;
    logic [CNT_W-1:0]            n_empl;
    logic [CNT_W-1:0]            s_empl;
    logic [CNT_W-1:0]            eject_empl;
    logic [NUM_PORTS-1:0]        full;
    logic                        ovf_err;
    logic                        udf_err;

    modport master (
        output wr_en, wr_flit, rd_en,
        input  rd_flit, e_empl, w_empl, n_empl, s_empl, eject_empl, full, ovf_err, udf_err
    );

    modport slave (
        input  wr_en, wr_flit, rd_en,
        output rd_flit, e_empl, w_empl, n_empl, s_empl, eject_empl, full, ovf_err, udf_err
    );

endinterface

// File: rtl/out_port_buffers_out_fifo.sv
// Single-port first-word-fall-through circular FIFO; DEPTH need not be a power of two.
// A pop frees its slot in the same cycle, so a full FIFO accepts a concurrent push.
module out_fifo
    import out_port_buffers_pkg::*;
#(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [FLIT_W-1:0] wr_flit,
    input  logic              rd_en,
    output logic [FLIT_W-1:0] rd_flit,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              ovf,
    output logic              udf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLIT_W-1:0] mem_q [(1 << PTR_W)];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_s;
    logic              pop_s;

    // Accept decisions, pointer wrap and occupancy update.
    always_comb begin
        pop_s    = rd_en && (count_q != {CNT_W{1'b0}});
        push_s   = wr_en && ((count_q < CNT_W'(DEPTH)) || pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flit storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_flit;
        end
    end

    assign rd_flit = (count_q != {CNT_W{1'b0}}) ? mem_q[rd_ptr_q] : {FLIT_W{1'b0}};
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign ovf     = wr_en && !push_s;
    assign udf     = rd_en && (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/out_port_buffers.sv
// Bank of five output-port FIFOs (R, L, U, D, EJ) between crossbar and link controllers.
// Occupancies feed the validity stage; drop/underflow events latch into sticky flags.
module out_port_buffers
    import out_port_buffers_pkg::*;
#(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    out_port_buffers_if.slave  bus
);

    logic [CNT_W-1:0]            cnt_s [NUM_PORTS];
    logic [NUM_PORTS*FLIT_W-1:0] rd_flit_s;
    logic [NUM_PORTS-1:0]        full_s;
    logic [NUM_PORTS-1:0]        ovf_s;
    logic [NUM_PORTS-1:0]        udf_s;
    logic                        ovf_err_q, ovf_err_d;
    logic                        udf_err_q, udf_err_d;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        out_fifo #(
            .FLIT_W (FLIT_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (bus.wr_en[g]),
            .wr_flit (bus.wr_flit[g*FLIT_W +: FLIT_W]),
            .rd_en   (bus.rd_en[g]),
            .rd_flit (rd_flit_s[g*FLIT_W +: FLIT_W]),
            .count   (cnt_s[g]),
            .full    (full_s[g]),
            .ovf     (ovf_s[g]),
            .udf     (udf_s[g])
        );
    end

    // Per-port error pulses accumulate until reset.
    always_comb begin
        ovf_err_d = ovf_err_q | (|ovf_s);
        udf_err_d = udf_err_q | (|udf_s);
    end

    // Sticky error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign bus.rd_flit    = rd_flit_s;
    assign bus.full       = full_s;
    assign bus.e_empl     = cnt_s[PORT_R];
    assign bus.w_empl     = cnt_s[PORT_L];
    assign bus.n_empl     = cnt_s[PORT_U];
    assign bus.s_empl     = cnt_s[PORT_D];
    assign bus.eject_empl = cnt_s[PORT_EJ];
    assign bus.ovf_err    = ovf_err_q;
    assign bus.udf_err    = udf_err_q;

endmodule

// File: tb/tb_out_port_buffers.sv
// Directed and randomized checks of out_port_buffers against a queue-based reference model.
module tb_out_port_buffers;
    import out_port_buffers_pkg::*;

    localparam int FW = 32;
    localparam int DP = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic [31:0] mq [5][$];
    logic        m_ovf;
    logic        m_udf;

    out_port_buffers_if #(.FLIT_W(FW)) bus ();

    out_port_buffers #(.FLIT_W(FW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] empl_of(input int p);
        case (p)
            PORT_R:  return bus.e_empl;
            PORT_L:  return bus.w_empl;
            PORT_U:  return bus.n_empl;
            PORT_D:  return bus.s_empl;
            default: return bus.eject_empl;
        endcase
    endfunction

    function automatic logic [5*FW-1:0] at(input int p, input logic [31:0] v);
        logic [5*FW-1:0] r;
        r = '0;
        r[p*FW +: FW] = v;
        return r;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 5; p++) mq[p].delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] we, input logic [4:0] re, input logic [5*FW-1:0] fl);
        for (int p = 0; p < 5; p++) begin
            int  n;
            bit  pop_ok;
            bit  push_ok;
            n       = mq[p].size();
            pop_ok  = re[p] && (n > 0);
            push_ok = we[p] && ((n < DP) || pop_ok);
            if (re[p] && n == 0) m_udf = 1'b1;
            if (we[p] && !push_ok) m_ovf = 1'b1;
            if (pop_ok) void'(mq[p].pop_front());
            if (push_ok) mq[p].push_back(fl[p*FW +: FW]);
        end
    endtask

    task automatic step(input logic [4:0] we, input logic [4:0] re, input logic [5*FW-1:0] fl);
        bus.wr_en   = we;
        bus.rd_en   = re;
        bus.wr_flit = fl;
        model_step(we, re, fl);
        @(posedge clk);
        #1;
        bus.wr_en = 5'b00000;
        bus.rd_en = 5'b00000;
    endtask

    task automatic check_all(input string ctx);
        for (int p = 0; p < 5; p++) begin
            logic [31:0] head;
            head = (mq[p].size() > 0) ? mq[p][0] : 32'h0;
            chk($sformatf("%s empl[%0d]", ctx, p), 32'(empl_of(p)), 32'(mq[p].size()));
            chk($sformatf("%s full[%0d]", ctx, p), 32'(bus.full[p]), 32'(mq[p].size() == DP));
            chk($sformatf("%s rd_flit[%0d]", ctx, p), bus.rd_flit[p*FW +: FW], head);
        end
        chk({ctx, " ovf_err"}, 32'(bus.ovf_err), 32'(m_ovf));
        chk({ctx, " udf_err"}, 32'(bus.udf_err), 32'(m_udf));
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        bus.wr_en   = 5'b00000;
        bus.rd_en   = 5'b00000;
        bus.wr_flit = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Fill and drain R
        for (int i = 0; i < 4; i++) begin
            step(5'b10000, 5'b00000, at(PORT_R, 32'hA0 + 32'(i)));
            chk("fill e_empl", 32'(bus.e_empl), 32'(i + 1));
            check_all("fill");
        end
        chk("fill full_r", 32'(bus.full[PORT_R]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain head", bus.rd_flit[PORT_R*FW +: FW], 32'hA0 + 32'(i));
            step(5'b00000, 5'b10000, '0);
            chk("drain e_empl", 32'(bus.e_empl), 32'(3 - i));
            check_all("drain");
        end
        chk("drain ovf", 32'(bus.ovf_err), 32'd0);
        chk("drain udf", 32'(bus.udf_err), 32'd0);

        // Full EJ with concurrent push and pop
        for (int i = 0; i < 4; i++) step(5'b00001, 5'b00000, at(PORT_EJ, 32'hB0 + 32'(i)));
        step(5'b00001, 5'b00001, at(PORT_EJ, 32'hC0));
        chk("ej empl", 32'(bus.eject_empl), 32'd4);
        chk("ej head", bus.rd_flit[PORT_EJ*FW +: FW], 32'hB1);
        chk("ej ovf", 32'(bus.ovf_err), 32'd0);
        for (int i = 0; i < 3; i++) step(5'b00000, 5'b00001, '0);
        chk("ej new head", bus.rd_flit[PORT_EJ*FW +: FW], 32'hC0);
        check_all("ej");

        // Asynchronous reset with R holding three flits
        for (int i = 0; i < 3; i++) step(5'b10000, 5'b00000, at(PORT_R, 32'hE0 + 32'(i)));
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst e_empl", 32'(bus.e_empl), 32'd0);
        chk("rst rd_flit", bus.rd_flit[PORT_R*FW +: FW], 32'h0);
        check_all("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(5'b10000, 5'b00000, at(PORT_R, 32'hD0));
        chk("post rst e_empl", 32'(bus.e_empl), 32'd1);
        chk("post rst head", bus.rd_flit[PORT_R*FW +: FW], 32'hD0);

        // Overflow on U
        for (int i = 0; i < 5; i++) step(5'b00100, 5'b00000, at(PORT_U, 32'h50 + 32'(i)));
        chk("ovf n_empl", 32'(bus.n_empl), 32'd4);
        chk("ovf flag", 32'(bus.ovf_err), 32'd1);
        step(5'b00000, 5'b00000, '0);
        chk("ovf sticky", 32'(bus.ovf_err), 32'd1);

        // Underflow on D
        step(5'b00000, 5'b00010, '0);
        chk("udf s_empl", 32'(bus.s_empl), 32'd0);
        chk("udf flag", 32'(bus.udf_err), 32'd1);

        // Push and pop on empty L
        step(5'b01000, 5'b01000, at(PORT_L, 32'h77));
        chk("l empl", 32'(bus.w_empl), 32'd1);
        chk("l head", bus.rd_flit[PORT_L*FW +: FW], 32'h77);
        check_all("l");

        // Random interleaved traffic on all ports
        reset = 1'b1;
        #1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            logic [4:0]      we;
            logic [4:0]      re;
            logic [5*FW-1:0] fl;
            for (int p = 0; p < 5; p++) begin
                we[p] = ($urandom_range(0, 9) < 6);
                re[p] = ($urandom_range(0, 9) < 5);
                fl[p*FW +: FW] = {8'(p), 24'($urandom)};
            end
            step(we, re, fl);
            check_all($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
